gorev_sirala: RTL and testbench

- Task scheduler in front of the image task unit. It queues task codes, issues each one to the unit with a start strobe, and admits exactly one frame of input pixels per task.
- It counts the unit's output beats and declares the task finished once the expected count is reached, then starts the next queued task.
- It sits between the host/control interface and the task unit, and gates the pixel source handshake.

---
 rtl/gorev_sirala.sv | 174 +++++++++++++++++
 tb/tb_gorev_sirala.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/gorev_sirala.sv
// Task scheduler: queues task codes, starts the task unit, admits one frame of pixels per task
// and counts output beats to completion. GRV_ZAMAN_ASIMI_EN adds an idle watchdog.
`timescale 1ns/1ps
module gorev_sirala #(
  parameter int unsigned GRV_BIT       = 3,
  parameter int unsigned FIFO_DERINLIK = 4,
  parameter int unsigned PIKSEL_SAYISI = 76800,
  parameter int unsigned HIST_CIKTI    = 768,
  parameter int unsigned SAYAC_BIT     = 17,
  parameter int unsigned ZAMAN_ASIMI   = 4096
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               gorev_gecerli_i,
  input  logic [GRV_BIT-1:0] gorev_i,
  output logic               gorev_hazir_o,
  output logic               basla_o,
  output logic [GRV_BIT-1:0] gorev_o,
  input  logic               kaynak_etkin_i,
  output logic               kaynak_hazir_o,
  output logic               birim_etkin_o,
  input  logic               birim_etkin_i,
  input  logic               stal_i,
  output logic               stal_o,
  output logic               mesgul_o,
  output logic               bitti_o,
  output logic               hata_o
);

  localparam int unsigned PtrW = (FIFO_DERINLIK > 1) ? $clog2(FIFO_DERINLIK) : 1;

  // Task codes: 1 = G_SXY ... 4 = H (histogram) ... 6 = G2BW_E
  localparam logic [GRV_BIT-1:0]   GrvIlk      = GRV_BIT'(1);
  localparam logic [GRV_BIT-1:0]   GrvHist     = GRV_BIT'(4);
  localparam logic [GRV_BIT-1:0]   GrvSon      = GRV_BIT'(6);
  localparam logic [SAYAC_BIT-1:0] PikselHedef = SAYAC_BIT'(PIKSEL_SAYISI);
  localparam logic [SAYAC_BIT-1:0] HistHedef   = SAYAC_BIT'(HIST_CIKTI);
  localparam logic [SAYAC_BIT-1:0] SayBir      = SAYAC_BIT'(1);
  localparam logic [PtrW-1:0]      PtrBir      = PtrW'(1);
  localparam logic [PtrW:0]        DolBir      = (PtrW + 1)'(1);
  localparam logic [PtrW:0]        DolMax      = (PtrW + 1)'(FIFO_DERINLIK);

  typedef enum logic [2:0] {StBos, StYukle, StAkis, StBosalt, StBitti} durum_e;

  durum_e               durum_q, durum_d;
  logic [GRV_BIT-1:0]   fifo_q [FIFO_DERINLIK];
  logic [PtrW-1:0]      yaz_ptr_q, oku_ptr_q;
  logic [PtrW:0]        doluluk_q, doluluk_d;
  logic [GRV_BIT-1:0]   aktif_q, aktif_d;
  logic [SAYAC_BIT-1:0] giris_q, giris_d, cikis_q, cikis_d, hedef;
  logic                 hata_q, hata_d;
  logic                 bos, dolu, push, pop, kod_gecerli;
  logic                 giris_vurus, cikis_vurus;
  logic [GRV_BIT-1:0]   bas_kod;

`ifdef GRV_ZAMAN_ASIMI_EN
  localparam int unsigned       BekW     = $clog2(ZAMAN_ASIMI + 1);
  localparam logic [BekW-1:0]   BekSinir = BekW'(ZAMAN_ASIMI);
  localparam logic [BekW-1:0]   BekBir   = BekW'(1);
  logic [BekW-1:0]              bekle_q, bekle_d;
`endif

  assign bos         = (doluluk_q == '0);
  assign dolu        = (doluluk_q == DolMax);
  assign push        = gorev_gecerli_i && !dolu;
  assign bas_kod     = fifo_q[oku_ptr_q];
  assign kod_gecerli = (bas_kod >= GrvIlk) && (bas_kod <= GrvSon);
  assign hedef       = (aktif_q == GrvHist) ? HistHedef : PikselHedef;

  always_comb begin
    doluluk_d = doluluk_q;
    if (push && !pop)      doluluk_d = doluluk_q + DolBir;
    else if (pop && !push) doluluk_d = doluluk_q - DolBir;
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[yaz_ptr_q] <= gorev_i;
  end

  always_comb begin
    durum_d        = durum_q;
    aktif_d        = aktif_q;
    giris_d        = giris_q;
    cikis_d        = cikis_q;
    hata_d         = 1'b0;
    pop            = 1'b0;
    kaynak_hazir_o = 1'b0;
    giris_vurus    = 1'b0;
    cikis_vurus    = 1'b0;
`ifdef GRV_ZAMAN_ASIMI_EN
    bekle_d        = '0;
`endif
    unique case (durum_q)
      StBos, StBitti: begin
        // Stall holds the queue head; a stalled BITTI still ends after one cycle.
        durum_d = StBos;
        if (!stal_i && !bos) begin
          pop = 1'b1;
          if (kod_gecerli) begin
            aktif_d = bas_kod;
            durum_d = StYukle;
          end else begin
            hata_d = 1'b1;
          end
        end
      end
      StYukle: begin
        giris_d = '0;
        cikis_d = '0;
        if (!stal_i) durum_d = StAkis;
      end
      StAkis, StBosalt: begin
        kaynak_hazir_o = (durum_q == StAkis) && !stal_i && (giris_q < PikselHedef);
        giris_vurus    = kaynak_etkin_i && kaynak_hazir_o;
        cikis_vurus    = birim_etkin_i && !stal_i && (cikis_q < hedef);
        if (giris_vurus) giris_d = giris_q + SayBir;
        if (cikis_vurus) cikis_d = cikis_q + SayBir;
        if (cikis_d == hedef) begin
          durum_d = StBitti;
        end else if ((durum_q == StAkis) && (giris_d == PikselHedef)) begin
          durum_d = StBosalt;
        end
`ifdef GRV_ZAMAN_ASIMI_EN
        if (stal_i)                          bekle_d = bekle_q;
        else if (giris_vurus || cikis_vurus) bekle_d = '0;
        else                                 bekle_d = bekle_q + BekBir;
        if (!stal_i && (bekle_d == BekSinir) && (durum_d != StBitti)) begin
          hata_d  = 1'b1;
          durum_d = StBos;
        end
`endif
      end
      default: durum_d = StBos;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_q   <= StBos;
      yaz_ptr_q <= '0;
      oku_ptr_q <= '0;
      doluluk_q <= '0;
      aktif_q   <= '0;
      giris_q   <= '0;
      cikis_q   <= '0;
      hata_q    <= 1'b0;
`ifdef GRV_ZAMAN_ASIMI_EN
      bekle_q   <= '0;
`endif
    end else begin
      durum_q   <= durum_d;
      doluluk_q <= doluluk_d;
      aktif_q   <= aktif_d;
      giris_q   <= giris_d;
      cikis_q   <= cikis_d;
      hata_q    <= hata_d;
      if (push) yaz_ptr_q <= yaz_ptr_q + PtrBir;
      if (pop)  oku_ptr_q <= oku_ptr_q + PtrBir;
`ifdef GRV_ZAMAN_ASIMI_EN
      bekle_q   <= bekle_d;
`endif
    end
  end

  assign gorev_hazir_o = !dolu;
  assign basla_o       = (durum_q == StYukle);
  assign gorev_o       = aktif_q;
  assign birim_etkin_o = giris_vurus;
  assign stal_o        = stal_i;
  assign mesgul_o      = (durum_q != StBos);
  assign bitti_o       = (durum_q == StBitti);
  assign hata_o        = hata_q;

endmodule

// File: tb/tb_gorev_sirala.sv
// Randomised bench for gorev_sirala against a transaction-level model of the task unit and
// scheduler (task order, frame size, completion timing, stall behaviour).
`timescale 1ns/1ps
module tb_gorev_sirala;
  localparam int unsigned Pix = 16, Hist = 48, Derinlik = 4, Zaman = 8;

  logic       clk_i = 1'b0, rstn_i = 1'b0;
  logic       gorev_gecerli_i = 1'b0, kaynak_etkin_i = 1'b0, birim_etkin_i = 1'b0, stal_i = 1'b0;
  logic [2:0] gorev_i = '0, gorev_o;
  logic       gorev_hazir_o, basla_o, kaynak_hazir_o, birim_etkin_o, stal_o;
  logic       mesgul_o, bitti_o, hata_o;

  always #5 clk_i = ~clk_i;

  gorev_sirala #(
    .GRV_BIT(3), .FIFO_DERINLIK(Derinlik), .PIKSEL_SAYISI(Pix), .HIST_CIKTI(Hist),
    .SAYAC_BIT(17), .ZAMAN_ASIMI(Zaman)
  ) u_dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .gorev_gecerli_i(gorev_gecerli_i), .gorev_i(gorev_i),
    .gorev_hazir_o(gorev_hazir_o), .basla_o(basla_o), .gorev_o(gorev_o),
    .kaynak_etkin_i(kaynak_etkin_i), .kaynak_hazir_o(kaynak_hazir_o),
    .birim_etkin_o(birim_etkin_o), .birim_etkin_i(birim_etkin_i), .stal_i(stal_i),
    .stal_o(stal_o), .mesgul_o(mesgul_o), .bitti_o(bitti_o), .hata_o(hata_o)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state
  int         cyc = 0;
  int         due_q[$];
  logic [2:0] exp_q[$];
  bit         task_active = 0, hist = 0, unit_mute = 0, next_basla_exp = 0;
  bit         basla_prev = 0, stal_prev = 0, bitti_prev = 0, hata_prev = 0;
  int         in_cnt = 0, out_cnt = 0, hedef = 0, done_cyc = -100, last_in_cyc = 0;
  int         hata_cnt = 0, basla_cnt = 0, bitti_cnt = 0, hata_cyc = 0;
  int         basla_len = 0, last_basla_len = 0;
  bit         src_always = 1, stal_rand = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (!rstn_i) begin
      task_active = 0; due_q.delete(); exp_q.delete(); next_basla_exp = 0;
      basla_prev = 0; stal_prev = 0; bitti_prev = 0; hata_prev = 0;
    end else begin
      if (next_basla_exp) chk("ardisik_basla", basla_o, 1);
      next_basla_exp = 0;
      if (basla_prev) begin
        if (stal_prev) chk("basla_tut", basla_o, 1);
        else           chk("basla_birak", basla_o, 0);
      end
      if (basla_o && !basla_prev) begin
        basla_cnt++;
        basla_len = 0;
        if (exp_q.size() == 0) chk("basla_beklenmedik", basla_o, 0);
        else chk("gorev_sirasi", gorev_o, exp_q.pop_front());
        task_active = 1; in_cnt = 0; out_cnt = 0; done_cyc = -100;
        hist  = (gorev_o == 3'd4);
        hedef = hist ? Hist : Pix;
      end
      if (basla_o) basla_len++;
      else if (basla_prev) last_basla_len = basla_len;

      chk("kaynak_hazir", kaynak_hazir_o,
          task_active && !basla_o && !bitti_o && !stal_i && (in_cnt < Pix));
      chk("birim_etkin", birim_etkin_o, kaynak_etkin_i && kaynak_hazir_o);

      if (bitti_o) begin
        chk("bitti_aktif", task_active, 1);
        chk("bitti_zaman", cyc, done_cyc + 1);
        chk("bitti_giris", in_cnt, Pix);
        if (bitti_prev) chk("bitti_darbe", bitti_prev, 0);
        bitti_cnt++;
        task_active = 0;
        if (exp_q.size() > 0 && !stal_i) next_basla_exp = 1;
      end
      if (hata_o) begin
        chk("hata_darbe", hata_prev, 0);
        hata_cnt++;
        hata_cyc = cyc;
        task_active = 0;
      end

      if (birim_etkin_o) begin
        in_cnt++;
        last_in_cyc = cyc;
        if (!unit_mute) begin
          if (!hist) due_q.push_back(cyc + 3);
          else if (in_cnt == Pix) for (int i = 0; i < Hist + 1; i++) due_q.push_back(cyc + 2 + i);
        end
      end
      if (birim_etkin_i && !stal_i) begin
        if (due_q.size() > 0) void'(due_q.pop_front());
        if (task_active && out_cnt < hedef) begin
          out_cnt++;
          if (out_cnt == hedef) done_cyc = cyc;
        end
      end
      basla_prev = basla_o; stal_prev = stal_i; bitti_prev = bitti_o; hata_prev = hata_o;
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
    birim_etkin_i  = (due_q.size() > 0) && (due_q[0] <= cyc);
    kaynak_etkin_i = src_always ? 1'b1 : ($urandom_range(0, 3) != 0);
    if (stal_rand) stal_i = ($urandom_range(0, 7) == 0);
  endtask

  task automatic push(input logic [2:0] code);
    int n = 0;
    while (!gorev_hazir_o && n < 500) begin tick(); n++; end
    chk("push_hazir", gorev_hazir_o, 1);
    gorev_gecerli_i = 1'b1; gorev_i = code;
    tick();
    gorev_gecerli_i = 1'b0;
    if (code >= 3'd1 && code <= 3'd6) exp_q.push_back(code);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((mesgul_o || exp_q.size() > 0 || due_q.size() > 0) && n < budget) begin
      tick(); n++;
    end
    chk("bosta_mesgul", mesgul_o, 0);
    chk("bosta_kuyruk", exp_q.size(), 0);
  endtask

  int b0, h0, c0, n;

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_cikis", {basla_o, mesgul_o, bitti_o, hata_o, kaynak_hazir_o, birim_etkin_o, gorev_o}, 0);
    rstn_i = 1'b1;
    tick();
    chk("reset_hazir", gorev_hazir_o, 1);

    // Single task, latency from push to start
    push(3'd1);
    @(negedge clk_i); chk("gecikme_1", basla_o, 0);
    @(negedge clk_i); chk("gecikme_2", basla_o, 1);
    wait_idle(300);
    chk("t1_bitti", bitti_cnt, 1);

    // Histogram task with one surplus output beat
    push(3'd4);
    wait_idle(500);
    repeat (4) tick();
    chk("hist_bitti", bitti_cnt, 2);
    chk("hist_mesgul", mesgul_o, 0);

    // Fill queue while stalled, then run back to back under random stall/source
    stal_i = 1'b1;
    push(3'd1); push(3'd2); push(3'd3); push(3'd5);
    chk("kuyruk_dolu", gorev_hazir_o, 0);
    chk("stal_bos", mesgul_o, 0);
    stal_i = 1'b0; src_always = 0; stal_rand = 1;
    push(3'd6);
    wait_idle(4000);
    chk("sira_bitti", bitti_cnt, 7);

    // Stall during start and mid-stream
    stal_rand = 0; stal_i = 1'b0; src_always = 1;
    repeat (2) tick();
    push(3'd2);
    tick();
    stal_i = 1'b1;
    repeat (5) tick();
    stal_i = 1'b0;
    n = 0;
    while (in_cnt < 5 && n < 100) begin tick(); n++; end
    stal_i = 1'b1;
    c0 = in_cnt;
    repeat (4) tick();
    chk("stal_giris_donuk", in_cnt, c0);
    chk("basla_sure", last_basla_len, 6);
    stal_i = 1'b0;
    wait_idle(300);
    chk("stal_bitti", bitti_cnt, 8);

    // Invalid code
    h0 = hata_cnt; b0 = basla_cnt;
    push(3'd7);
    repeat (4) tick();
    chk("gecersiz_hata", hata_cnt, h0 + 1);
    chk("gecersiz_basla", basla_cnt, b0);
    chk("gecersiz_mesgul", mesgul_o, 0);
    push(3'd3);
    wait_idle(300);
    chk("gecersiz_sonra", bitti_cnt, 9);

`ifdef GRV_ZAMAN_ASIMI_EN
    unit_mute = 1; h0 = hata_cnt; b0 = bitti_cnt;
    push(3'd1);
    n = 0;
    while (hata_cnt == h0 && n < 200) begin tick(); n++; end
    chk("wd_hata", hata_cnt, h0 + 1);
    chk("wd_zaman", hata_cyc, last_in_cyc + Zaman + 1);
    chk("wd_bitti_yok", bitti_cnt, b0);
    tick();
    chk("wd_mesgul", mesgul_o, 0);
    unit_mute = 0;
`endif

    // Reset in the middle of a task
    b0 = bitti_cnt;
    push(3'd5);
    n = 0;
    while (in_cnt < 4 && n < 100) begin tick(); n++; end
    rstn_i = 1'b0;
    #1;
    chk("reset_anlik", {basla_o, mesgul_o, bitti_o, hata_o, kaynak_hazir_o, birim_etkin_o, gorev_o}, 0);
    repeat (2) tick();
    rstn_i = 1'b1;
    tick();
    chk("reset_sonra_hazir", gorev_hazir_o, 1);
    chk("reset_sonra_mesgul", mesgul_o, 0);
    repeat (3) tick();
    chk("reset_bitti_yok", bitti_cnt, b0);
    push(3'd2);
    wait_idle(300);
    chk("reset_sonra_gorev", bitti_cnt, b0 + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
